pool_lay1: RTL and testbench

- 2x2, stride-2 pooling stage directly downstream of the first convolution layer.
- Consumes one 28-pixel row of 16-bit post-ReLU conv results per input strobe.
- Emits one 14-pixel pooled row for every two input rows, i.e. a 14x14 map per 28x28 frame.
- Output feeds the second convolution layer's row input.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/pool_cmp2.sv | 22 ++
 rtl/pool_lay1.sv | 95 +++++++++
 tb/tb_pool_lay1.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and types, used by the conv and pool layers.
// POOL_AVG_EN selects average pooling instead of max pooling; it changes the
// accumulator growth of each pool_cmp2 stage.
package cnn_pkg;

    localparam int DW    = 16;              // pixel width, signed fixed point
    localparam int FRAC  = 10;              // fractional bits of a pixel
    localparam int COLS  = 28;              // input pixels per row
    localparam int ROWS  = 28;              // input rows per frame
    localparam int ROW_W = $clog2(ROWS);    // row / line index width

    typedef logic signed [DW-1:0] pix_t;

`ifdef POOL_AVG_EN
    // Each pairwise reduce is an add, so every stage grows by one bit.
    localparam int ACC_GROW = 1;
`else
    // Each pairwise reduce is a max, so width is preserved.
    localparam int ACC_GROW = 0;
`endif

endpackage

// File: rtl/pool_cmp2.sv
// Two-input signed reduce used for both horizontal and vertical pooling.
// Max of the two operands by default; under POOL_AVG_EN a widening sum.
module pool_cmp2
    import cnn_pkg::*;
#(
    parameter int IW = cnn_pkg::DW
) (
    input  logic signed [IW-1:0]          i_a,
    input  logic signed [IW-1:0]          i_b,
    output logic signed [IW+ACC_GROW-1:0] o_y
);

    // Reduce the operand pair.
    always_comb begin
`ifdef POOL_AVG_EN
        o_y = {i_a[IW-1], i_a} + {i_b[IW-1], i_b};
`else
        o_y = (i_a > i_b) ? i_a : i_b;
`endif
    end

endmodule

// File: rtl/pool_lay1.sv
// 2x2 stride-2 pooling after conv layer 1: one 28-pixel row in per strobe,
// one 14-pixel pooled row out per pair of input rows.
// Define POOL_AVG_EN for average pooling; max pooling otherwise.
module pool_lay1
    import cnn_pkg::*;
#(
    parameter int COLS = cnn_pkg::COLS,
    parameter int ROWS = cnn_pkg::ROWS,
    parameter int DW   = cnn_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [COLS*DW-1:0]       in_data,
    input  logic                     frame_start,
    output logic                     out_valid,
    output logic [(COLS/2)*DW-1:0]   out_data,
    output logic [ROW_W-1:0]         out_row,
    output logic                     frame_done
);

    localparam int HC = COLS / 2;           // pooled pixels per row
    localparam int HW = DW + ACC_GROW;      // horizontal reduce width
    localparam int VW = HW + ACC_GROW;      // vertical reduce width

    logic signed [HW-1:0]    w_h [HC];
    logic signed [VW-1:0]    w_v [HC];
    logic [HC*DW-1:0]        w_pool;
    logic                    w_last;

    logic [HC-1:0][HW-1:0]   r_buf;
    logic [ROW_W-1:0]        r_cnt;
    logic                    r_out_valid;
    logic [HC*DW-1:0]        r_out_data;
    logic [ROW_W-1:0]        r_out_row;
    logic                    r_frame_done;

    for (genvar j = 0; j < HC; j++) begin : g_col
        pool_cmp2 #(.IW(DW)) u_h (
            .i_a (in_data[(2*j)*DW +: DW]),
            .i_b (in_data[(2*j+1)*DW +: DW]),
            .o_y (w_h[j])
        );

        pool_cmp2 #(.IW(HW)) u_v (
            .i_a (r_buf[j]),
            .i_b (w_h[j]),
            .o_y (w_v[j])
        );

`ifdef POOL_AVG_EN
        // Divide the 4-pixel sum by 4 (floor) and keep the low DW bits.
        assign w_pool[j*DW +: DW] = w_v[j][DW+1:2];
`else
        assign w_pool[j*DW +: DW] = w_v[j];
`endif
    end

    assign w_last = (r_cnt == ROW_W'(ROWS - 1));

    // Row sequencing: buffer even rows, emit the pooled result on odd rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_row    <= '0;
            r_frame_done <= 1'b0;
        end else if (!in_valid) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (frame_start || !r_cnt[0]) begin
            // frame_start forces this row to be row 0, dropping any pending row.
            for (int unsigned j = 0; j < HC; j++) begin
                r_buf[j] <= w_h[j];
            end
            r_cnt        <= frame_start ? ROW_W'(1) : r_cnt + 1'b1;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_data   <= w_pool;
            r_out_valid  <= 1'b1;
            r_out_row    <= r_cnt >> 1;
            r_frame_done <= w_last;
            r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_row    = r_out_row;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_lay1.sv
// Scoreboard bench for pool_lay1: stimulus pushes expected pooled rows computed
// from whole 2x2 pixel blocks, a negedge monitor pops and compares.
module tb_pool_lay1;
    import cnn_pkg::*;

    localparam int HC = COLS / 2;
    typedef logic [COLS*DW-1:0] row_t;
    typedef logic [HC*DW-1:0]   prow_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    row_t              in_data = '0;
    logic              frame_start = 1'b0;
    logic              out_valid;
    prow_t             out_data;
    logic [ROW_W-1:0]  out_row;
    logic              frame_done;

    pool_lay1 #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row     (out_row),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        prow_t data;
        int    row;
        bit    done;
        int    due;
    } exp_t;
    exp_t sbq[$];

    // Reference state: position in frame and the buffered upper row.
    int   m_row = 0;
    row_t m_upper;

    task automatic chk(input string nm, input prow_t act, input prow_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int px(input row_t r, input int k);
        logic signed [DW-1:0] p;
        p = r[k*DW +: DW];
        return int'(p);
    endfunction

    // Pool one 2x2 block per output column straight from the two rows.
    function automatic prow_t pool_rows(input row_t top, input row_t bot);
        prow_t res;
        int    v[4];
        int    r;
        logic [31:0] rb;
        res = '0;
        for (int j = 0; j < HC; j++) begin
            v[0] = px(top, 2*j); v[1] = px(top, 2*j+1);
            v[2] = px(bot, 2*j); v[3] = px(bot, 2*j+1);
`ifdef POOL_AVG_EN
            r = (v[0] + v[1] + v[2] + v[3]) >>> 2;
`else
            r = v[0];
            for (int i = 1; i < 4; i++) if (v[i] > r) r = v[i];
`endif
            rb = r;
            res[j*DW +: DW] = rb[DW-1:0];
        end
        return res;
    endfunction

    task automatic send_row(input row_t d, input bit fs);
        exp_t e;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        frame_start = fs;
        if (fs) m_row = 0;
        if (m_row % 2 == 0) begin
            m_upper = d;
        end else begin
            e.data = pool_rows(m_upper, d);
            e.row  = m_row / 2;
            e.done = (m_row == ROWS - 1);
            e.due  = cyc + 1;
            sbq.push_back(e);
        end
        m_row = (m_row + 1) % ROWS;
    endtask

    task automatic idle(input int n, input bit fs);
        repeat (n) begin
            @(negedge clk);
            in_valid    = 1'b0;
            frame_start = fs;
            in_data     = {COLS*DW/32{$urandom}};
        end
        frame_start = 1'b0;
    endtask

    function automatic row_t row_const(input logic [DW-1:0] v);
        row_t d;
        for (int k = 0; k < COLS; k++) d[k*DW +: DW] = v;
        return d;
    endfunction

    function automatic row_t row_lin(input int mul);
        row_t d;
        logic [31:0] t;
        for (int k = 0; k < COLS; k++) begin
            t = k * mul;
            d[k*DW +: DW] = t[DW-1:0];
        end
        return d;
    endfunction

    function automatic row_t row_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        row_t d;
        for (int k = 0; k < COLS; k++) d[k*DW +: DW] = (k % 2 == 0) ? a : b;
        return d;
    endfunction

    function automatic row_t row_rand();
        row_t d;
        logic [31:0] t;
        for (int k = 0; k < COLS; k++) begin
            t = $urandom;
            d[k*DW +: DW] = t[DW-1:0];
        end
        return d;
    endfunction

    // Monitor: every output strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (frame_done && !out_valid) begin
                total++; bad++;
                $display("FAIL frame_done_alone: got frame_done=1 out_valid=0 expected frame_done=0");
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got out_valid=1 row=%0d expected no output", out_row);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_row", prow_t'(out_row), prow_t'(e.row));
                    chk("frame_done", prow_t'(frame_done), prow_t'(e.done));
                    chk("latency_cycle", prow_t'(cyc), prow_t'(e.due));
                end
            end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                total++; bad++;
                $display("FAIL missing_out: got no out_valid at cycle %0d expected row %0d", e.due, e.row);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, prow_t'(out_valid), '0);
        chk({tag, "_data"}, out_data, '0);
        chk({tag, "_row"}, prow_t'(out_row), '0);
        chk({tag, "_done"}, prow_t'(frame_done), '0);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2, 1'b0);

        // Max basic: row pixels k then 2k.
        send_row(row_lin(1), 1'b1);
        send_row(row_lin(2), 1'b0);
        idle(3, 1'b0);

        // Signed compare, both row orders.
        send_row(row_const(16'hFFFF), 1'b1);
        send_row(row_const(16'h0001), 1'b0);
        send_row(row_const(16'h0001), 1'b1);
        send_row(row_const(16'hFFFF), 1'b0);
        idle(2, 1'b0);

        // Full frame back to back, row r pixels = r.
        for (int r = 0; r < ROWS; r++) send_row(row_const(DW'(r)), r == 0);
        idle(3, 1'b0);

        // Resync: third row is dropped by the frame_start row.
        send_row(row_const(16'd1), 1'b0);
        send_row(row_const(16'd2), 1'b0);
        send_row(row_const(16'd3), 1'b0);
        idle(1, 1'b1);   // frame_start without in_valid is ignored
        send_row(row_const(16'd5), 1'b1);
        send_row(row_const(16'd9), 1'b0);
        idle(3, 1'b0);

        // Average-mode style patterns and saturation-range values.
        send_row(row_pair(16'd4, 16'd8), 1'b1);
        send_row(row_pair(16'd12, 16'd16), 1'b0);
        send_row(row_const(16'h7FFF), 1'b0);
        send_row(row_const(16'h7FFF), 1'b0);
        send_row(row_const(16'h8000), 1'b0);
        send_row(row_pair(16'h8000, 16'h8001), 1'b0);
        idle(3, 1'b0);

        // Async reset mid-frame, after an even row.
        send_row(row_rand(), 1'b1);
        send_row(row_rand(), 1'b0);
        send_row(row_rand(), 1'b0);
        send_row(row_rand(), 1'b0);
        send_row(row_rand(), 1'b0);
        idle(3, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst   = 1'b1;
        m_row = 0;
        send_row(row_const(16'd7), 1'b0);
        send_row(row_const(16'd6), 1'b0);
        idle(2, 1'b0);

        // Randomized frames with gaps and occasional resyncs.
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), $urandom_range(0, 1) == 1);
                send_row(row_rand(), (r == 0) || ($urandom_range(0, 24) == 0));
            end
        end
        idle(2, 1'b0);

        for (int t = 0; t < 50 && sbq.size() != 0; t++) @(negedge clk);
        chk("scoreboard_drained", prow_t'(sbq.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
